conv_window_buf: RTL and testbench

Parametrised K×K sliding-window generator for raster-scan feature maps. It is the successor to the fixed 5×5 conv line buffer. It accepts one pixel per valid beat across CHANNELS parallel lanes and keeps K-1 line buffers per lane. It emits a full K×K×CHANNELS window, with output coordinates, only for windows lying entirely inside the frame and aligned to STRIDE. It sits between a layer's input stream (image or previous pooled map) and the conv MAC array.

---
 rtl/conv_window_buf.sv | 170 +++++++++++++++++
 tb/tb_conv_window_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buf.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_buf
//  Description : Parametrised KxK sliding-window generator with per-channel
//                line buffers, stride alignment and output-map coordinates.
//  Revision    : 1.0
// ============================================================================
module conv_window_buf #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12,
    parameter int K         = 5,
    parameter int CHANNELS  = 1,
    parameter int STRIDE    = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               valid_in,
    input  logic                               sof_in,
    input  logic [CHANNELS*DATA_BITS-1:0]      data_in,
    output logic [K*K*CHANNELS*DATA_BITS-1:0]  window_out,
    output logic                               valid_out,
    output logic [$clog2(HEIGHT)-1:0]          out_row,
    output logic [$clog2(WIDTH)-1:0]           out_col,
    output logic                               last_out
);

    localparam int C_CW = $clog2(WIDTH);
    localparam int C_RW = $clog2(HEIGHT);
    localparam int C_PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [C_CW-1:0] C_COL_LAST  = C_CW'(WIDTH - 1);
    localparam logic [C_RW-1:0] C_ROW_LAST  = C_RW'(HEIGHT - 1);
    localparam logic [C_CW-1:0] C_COL_FIRST = C_CW'(K - 1);
    localparam logic [C_RW-1:0] C_ROW_FIRST = C_RW'(K - 1);
    localparam logic [C_PW-1:0] C_PH_LAST   = C_PW'(STRIDE - 1);
    localparam logic [C_RW-1:0] C_OROW_LAST = C_RW'((HEIGHT - K) / STRIDE);
    localparam logic [C_CW-1:0] C_OCOL_LAST = C_CW'((WIDTH - K) / STRIDE);

    logic [C_CW-1:0] r_col;
    logic [C_RW-1:0] r_row;
    logic [C_PW-1:0] r_cph;
    logic [C_PW-1:0] r_rph;
    logic [C_CW-1:0] r_ocol;
    logic [C_RW-1:0] r_orow;

    logic            w_acc;
    logic [C_CW-1:0] w_c;
    logic [C_RW-1:0] w_r;
    logic [C_PW-1:0] w_cph;
    logic [C_PW-1:0] w_rph;
    logic [C_CW-1:0] w_ocol;
    logic [C_RW-1:0] w_orow;
    logic            w_col_ok;
    logic            w_row_ok;
    logic            w_eol;
    logic            w_emit;
    logic            w_last;

    // Position of the beat being accepted; sof forces (0,0).
    assign w_acc    = valid_in;
    assign w_c      = sof_in ? '0 : r_col;
    assign w_r      = sof_in ? '0 : r_row;
    // Phase and output counters restart at the first column/row that can
    // anchor a window, so stale values from a previous frame never matter.
    assign w_cph    = (w_c == C_COL_FIRST) ? '0 : r_cph;
    assign w_rph    = (w_r == C_ROW_FIRST) ? '0 : r_rph;
    assign w_ocol   = (w_c == C_COL_FIRST) ? '0 : r_ocol;
    assign w_orow   = (w_r == C_ROW_FIRST) ? '0 : r_orow;
    assign w_col_ok = (w_c >= C_COL_FIRST) && (w_cph == '0);
    assign w_row_ok = (w_r >= C_ROW_FIRST) && (w_rph == '0);
    assign w_eol    = (w_c == C_COL_LAST);
    assign w_emit   = w_acc && w_col_ok && w_row_ok;
    assign w_last   = (w_orow == C_OROW_LAST) && (w_ocol == C_OCOL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_cph     <= '0;
            r_rph     <= '0;
            r_ocol    <= '0;
            r_orow    <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            valid_out <= w_emit;
            last_out  <= w_emit && w_last;
            if (w_acc) begin
                r_col <= w_eol ? '0 : w_c + 1'b1;
                if (w_eol) begin
                    r_row <= (w_r == C_ROW_LAST) ? '0 : w_r + 1'b1;
                end else begin
                    r_row <= w_r;
                end
                if (w_c >= C_COL_FIRST) begin
                    r_cph <= (w_cph == C_PH_LAST) ? '0 : w_cph + 1'b1;
                end
                if (w_col_ok) begin
                    r_ocol <= w_ocol + 1'b1;
                end
                if (w_eol && (w_r >= C_ROW_FIRST)) begin
                    r_rph <= (w_rph == C_PH_LAST) ? '0 : w_rph + 1'b1;
                end
                if (w_eol && w_row_ok) begin
                    r_orow <= w_orow + 1'b1;
                end
                if (w_emit) begin
                    out_row <= w_orow;
                    out_col <= w_ocol;
                end
            end
        end
    end

    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [DATA_BITS-1:0] r_lb  [K-1][WIDTH];
            logic [DATA_BITS-1:0] r_win [K][K];
            logic [DATA_BITS-1:0] w_tap [K-1];
            logic [DATA_BITS-1:0] w_pix;

            assign w_pix = data_in[ch*DATA_BITS +: DATA_BITS];

            // w_tap[k] is line buffer L(k+1) at the current column, pre-update.
            for (genvar k = 0; k < K - 1; k++) begin : g_tap
                assign w_tap[k] = r_lb[k][w_c];
            end

            always_ff @(posedge clk) begin
                if (w_acc) begin
                    r_lb[0][w_c] <= w_pix;
                    for (int k = 1; k < K - 1; k++) begin
                        r_lb[k][w_c] <= w_tap[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K; j++) begin
                            r_win[i][j] <= '0;
                        end
                    end
                end else if (w_acc) begin
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K - 1; j++) begin
                            r_win[i][j] <= r_win[i][j+1];
                        end
                    end
                    for (int i = 0; i < K - 1; i++) begin
                        r_win[i][K-1] <= w_tap[K-2-i];
                    end
                    r_win[K-1][K-1] <= w_pix;
                end
            end

            for (genvar i = 0; i < K; i++) begin : g_row
                for (genvar j = 0; j < K; j++) begin : g_col
                    assign window_out[(ch*K*K + i*K + j)*DATA_BITS +: DATA_BITS] = r_win[i][j];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_window_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_buf
//  Description : Directed self-checking bench: 12x12 K=5 two-channel instance
//                and an 8x8 K=3 stride-2 instance.
//  Revision    : 1.0
// ============================================================================
module tb_conv_window_buf;

    logic clk;
    logic rst_n;

    logic          valid_a, sof_a;
    logic [23:0]   data_a;
    logic [599:0]  window_a;
    logic          vout_a, last_a;
    logic [3:0]    orow_a, ocol_a;

    logic          valid_b, sof_b;
    logic [11:0]   data_b;
    logic [107:0]  window_b;
    logic          vout_b, last_b;
    logic [2:0]    orow_b, ocol_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int          a_pulses, b_pulses;
    logic [3:0]  a_exp_row, a_exp_col;
    logic [11:0] a_hold_pix;
    bit          a_hold_ok;

    conv_window_buf #(
        .WIDTH(12), .HEIGHT(12), .DATA_BITS(12), .K(5), .CHANNELS(2), .STRIDE(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_a), .sof_in(sof_a),
        .data_in(data_a), .window_out(window_a), .valid_out(vout_a),
        .out_row(orow_a), .out_col(ocol_a), .last_out(last_a)
    );

    conv_window_buf #(
        .WIDTH(8), .HEIGHT(8), .DATA_BITS(12), .K(3), .CHANNELS(1), .STRIDE(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_b), .sof_in(sof_b),
        .data_in(data_b), .window_out(window_b), .valid_out(vout_b),
        .out_row(orow_b), .out_col(ocol_b), .last_out(last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic a_pix(input int r, input int c, input bit sof);
        bit          exp_v;
        logic [11:0] e;
        valid_a = 1'b1;
        sof_a   = sof;
        data_a  = {12'(-(r*12 + c)), 12'(r*12 + c)};
        @(posedge clk); #1;
        exp_v = (r >= 4) && (c >= 4);
        if (vout_a === 1'b1) a_pulses++;
        check($sformatf("a_valid r%0d c%0d", r, c), 32'(vout_a), 32'(exp_v));
        check($sformatf("a_last r%0d c%0d", r, c), 32'(last_a), 32'(exp_v && r == 11 && c == 11));
        if (exp_v) begin
            check($sformatf("a_row r%0d c%0d", r, c), 32'(orow_a), 32'(r - 4));
            check($sformatf("a_col r%0d c%0d", r, c), 32'(ocol_a), 32'(c - 4));
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 5; j++) begin
                        e = 12'((r - 4 + i)*12 + (c - 4 + j));
                        if (ch == 1) e = -e;
                        check($sformatf("a_win ch%0d i%0d j%0d @r%0d c%0d", ch, i, j, r, c),
                              32'(window_a[(ch*25 + i*5 + j)*12 +: 12]), 32'(e));
                    end
                end
            end
            a_exp_row  = 4'(r - 4);
            a_exp_col  = 4'(c - 4);
            a_hold_pix = 12'(r*12 + c);
            a_hold_ok  = 1'b1;
        end else begin
            a_hold_ok = 1'b0;
        end
    endtask

    // Idle beat: pulses must drop, coordinates and window must hold.
    task automatic a_idle(input bit sof);
        valid_a = 1'b0;
        sof_a   = sof;
        data_a  = 24'($urandom);
        @(posedge clk); #1;
        check("a_idle_valid", 32'(vout_a), 32'd0);
        check("a_idle_last", 32'(last_a), 32'd0);
        check("a_idle_row", 32'(orow_a), 32'(a_exp_row));
        check("a_idle_col", 32'(ocol_a), 32'(a_exp_col));
        if (a_hold_ok) check("a_idle_win", 32'(window_a[24*12 +: 12]), 32'(a_hold_pix));
        sof_a = 1'b0;
    endtask

    task automatic a_frame(input bit gaps, input bit sof);
        int n;
        a_pulses = 0;
        n = 0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                a_pix(r, c, sof && n == 0);
                if (gaps && n[0]) a_idle(n % 29 == 5);
                if (gaps && $urandom_range(0, 15) == 0) begin
                    a_idle(1'b0);
                    a_idle(1'b0);
                    a_idle(1'b0);
                end
                n++;
            end
        end
        valid_a = 1'b0;
        sof_a   = 1'b0;
        check("a_pulse_count", 32'(a_pulses), 32'd64);
    endtask

    task automatic b_frame(input bit sof);
        bit exp_v;
        b_pulses = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                valid_b = 1'b1;
                sof_b   = sof && r == 0 && c == 0;
                data_b  = 12'(r*8 + c);
                @(posedge clk); #1;
                exp_v = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
                if (vout_b === 1'b1) b_pulses++;
                check($sformatf("b_valid r%0d c%0d", r, c), 32'(vout_b), 32'(exp_v));
                check($sformatf("b_last r%0d c%0d", r, c), 32'(last_b), 32'(exp_v && r == 6 && c == 6));
                if (exp_v) begin
                    check($sformatf("b_row r%0d c%0d", r, c), 32'(orow_b), 32'((r - 2) / 2));
                    check($sformatf("b_col r%0d c%0d", r, c), 32'(ocol_b), 32'((c - 2) / 2));
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            check($sformatf("b_win i%0d j%0d @r%0d c%0d", i, j, r, c),
                                  32'(window_b[(i*3 + j)*12 +: 12]),
                                  32'((r - 2 + i)*8 + (c - 2 + j)));
                        end
                    end
                end
            end
        end
        valid_b = 1'b0;
        sof_b   = 1'b0;
        check("b_pulse_count", 32'(b_pulses), 32'd9);
    endtask

    initial begin
        rst_n   = 1'b1;
        valid_a = 1'b0; sof_a = 1'b0; data_a = '0;
        valid_b = 1'b0; sof_b = 1'b0; data_b = '0;
        a_exp_row = '0; a_exp_col = '0; a_hold_pix = '0; a_hold_ok = 1'b0;
        a_pulses = 0; b_pulses = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 32'(vout_a), 32'd0);
        check("rst_a_last", 32'(last_a), 32'd0);
        check("rst_a_row", 32'(orow_a), 32'd0);
        check("rst_a_col", 32'(ocol_a), 32'd0);
        check("rst_a_win_nonzero", 32'(|window_a), 32'd0);
        check("rst_b_valid", 32'(vout_b), 32'd0);
        check("rst_b_last", 32'(last_b), 32'd0);
        check("rst_b_row", 32'(orow_b), 32'd0);
        check("rst_b_col", 32'(ocol_b), 32'd0);
        check("rst_b_win_nonzero", 32'(|window_b), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Baseline frame, then the same stream with gaps.
        a_frame(1'b0, 1'b1);
        a_idle(1'b0);
        a_frame(1'b1, 1'b1);
        a_idle(1'b0);

        // Partial frame, resync with sof at input pixel (6,3), then full frame.
        for (int n = 0; n < 6*12 + 3; n++) a_pix(n / 12, n % 12, n == 0);
        a_frame(1'b0, 1'b1);
        a_idle(1'b0);

        // Asynchronous reset right after a pulse, mid-cycle.
        for (int n = 0; n <= 5*12 + 6; n++) a_pix(n / 12, n % 12, n == 0);
        valid_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vout_a), 32'd0);
        check("arst_last", 32'(last_a), 32'd0);
        check("arst_row", 32'(orow_a), 32'd0);
        check("arst_col", 32'(ocol_a), 32'd0);
        check("arst_win_nonzero", 32'(|window_a), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        a_exp_row = '0;
        a_exp_col = '0;
        a_hold_ok = 1'b0;
        a_idle(1'b0);
        a_frame(1'b0, 1'b0);
        a_idle(1'b0);

        // Stride-2 instance: one frame with sof, one relying on counter wrap.
        b_frame(1'b1);
        b_frame(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
